// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM controller: FSM states, phase width
// and the per-channel output decision.
package pwm_pkg;

    localparam int         PHASE_W    = 8;
    localparam logic [7:0] PHASE_LAST = 8'hFF;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } pwm_state_e;

    // Full-scale duty (8'hFF) is forced high so the channel can reach 100%.
    function automatic logic chan_level(
        input logic               out_en,
        input logic               pwm_en,
        input logic [PHASE_W-1:0] duty,
        input logic [PHASE_W-1:0] phase
    );
        logic lvl;
        if (!out_en) begin
            lvl = 1'b0;
        end else if (!pwm_en) begin
            lvl = 1'b1;
        end else if (duty == PHASE_LAST) begin
            lvl = 1'b1;
        end else begin
            lvl = (phase < duty);
        end
        return lvl;
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler: produces a one-clk phase tick every CLK_DIV enabled clocks.
// The clear input holds the counter at zero while the controller is stopped.
module pwm_prescaler #(
    parameter int CLK_DIV = 13
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clear,
    output logic tick
);
    localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    always_comb begin
        tick  = en && (div_q == DIV_LAST);
        div_d = div_q;
        if (clear) begin
            div_d = '0;
        end else if (tick) begin
            div_d = '0;
        end else if (en) begin
            div_d = div_q + DIV_W'(1);
        end else begin
            div_d = div_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/pwm_controller.sv
// PWM controller: run/drain/stop FSM, 8-bit phase counter, staged config that
// commits atomically at a period boundary, and registered channel outputs.
module pwm_controller
    import pwm_pkg::*;
#(
    parameter int CLK_DIV = 13,
    parameter int CH      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               cfg_update,
    input  logic [CH-1:0]      cfg_out_en,
    input  logic [CH-1:0]      cfg_pwm_en,
    input  logic [PHASE_W-1:0] cfg_duty,
    output logic [CH-1:0]      pwm_out,
    output logic               period_start,
    output logic               cfg_pending,
    output logic               cfg_commit,
    output logic [1:0]         state_o
);
    pwm_state_e          state_q, state_d;
    logic [PHASE_W-1:0]  phase_q, phase_d;
    logic [CH-1:0]       stg_out_en_q, stg_pwm_en_q, act_out_en_q, act_pwm_en_q;
    logic [PHASE_W-1:0]  stg_duty_q, act_duty_q;
    logic                pending_q, pending_d;
    logic                commit_q, period_start_q;
    logic [CH-1:0]       pwm_q, pwm_d;
    logic                counting_s, tick_s, boundary_s, commit_s, bypass_s;

    assign counting_s = (state_q != ST_STOP);
    assign boundary_s = tick_s && (phase_q == PHASE_LAST);

    pwm_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .en    (counting_s),
        .clear (!counting_s),
        .tick  (tick_s)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STOP: begin
                if (run) state_d = ST_RUN;
                else     state_d = ST_STOP;
            end
            ST_RUN: begin
                if (!run) state_d = ST_DRAIN;
                else      state_d = ST_RUN;
            end
            ST_DRAIN: begin
                if (run)             state_d = ST_RUN;
                else if (boundary_s) state_d = ST_STOP;
                else                 state_d = ST_DRAIN;
            end
            default: state_d = ST_STOP;
        endcase
    end

    always_comb begin
        phase_d = phase_q;
        if (!counting_s) begin
            phase_d = '0;
        end else if (tick_s) begin
            phase_d = phase_q + 8'd1;
        end else begin
            phase_d = phase_q;
        end
    end

    // A strobe landing on the boundary bypasses staging and commits directly.
    always_comb begin
        bypass_s  = cfg_update && boundary_s;
        commit_s  = bypass_s || (pending_q && (!counting_s || boundary_s));
        pending_d = pending_q;
        if (cfg_update) begin
            pending_d = !boundary_s;
        end else if (commit_s) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end
    end

    always_comb begin
        pwm_d = '0;
        for (int i = 0; i < CH; i++) begin
            if (counting_s) begin
                pwm_d[i] = chan_level(act_out_en_q[i], act_pwm_en_q[i], act_duty_q, phase_q);
            end else begin
                pwm_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_STOP;
            phase_q        <= '0;
            stg_out_en_q   <= '0;
            stg_pwm_en_q   <= '0;
            stg_duty_q     <= '0;
            act_out_en_q   <= '0;
            act_pwm_en_q   <= '0;
            act_duty_q     <= '0;
            pending_q      <= 1'b0;
            commit_q       <= 1'b0;
            period_start_q <= 1'b0;
            pwm_q          <= '0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            pending_q      <= pending_d;
            commit_q       <= commit_s;
            period_start_q <= (state_q == ST_RUN) && boundary_s;
            pwm_q          <= pwm_d;
            if (cfg_update) begin
                stg_out_en_q <= cfg_out_en;
                stg_pwm_en_q <= cfg_pwm_en;
                stg_duty_q   <= cfg_duty;
            end
            if (bypass_s) begin
                act_out_en_q <= cfg_out_en;
                act_pwm_en_q <= cfg_pwm_en;
                act_duty_q   <= cfg_duty;
            end else if (commit_s) begin
                act_out_en_q <= stg_out_en_q;
                act_pwm_en_q <= stg_pwm_en_q;
                act_duty_q   <= stg_duty_q;
            end
        end
    end

    assign pwm_out      = pwm_q;
    assign period_start = period_start_q;
    assign cfg_pending  = pending_q;
    assign cfg_commit   = commit_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_pwm_controller.sv
// Directed testbench for pwm_controller with CLK_DIV=2 (512-clk PWM period).
module tb_pwm_controller;

    logic        clk;
    logic        rst;
    logic        run;
    logic        cfg_update;
    logic [15:0] cfg_out_en;
    logic [15:0] cfg_pwm_en;
    logic [7:0]  cfg_duty;
    logic [15:0] pwm_out;
    logic        period_start;
    logic        cfg_pending;
    logic        cfg_commit;
    logic [1:0]  state_o;

    int n_checks = 0;
    int n_fail   = 0;

    int          hi_cnt [16];
    int          ps_cnt, cm_cnt, pd_cnt, dr_cnt, hi_total;
    logic [15:0] win [0:1535];

    pwm_controller #(.CLK_DIV(2), .CH(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .run          (run),
        .cfg_update   (cfg_update),
        .cfg_out_en   (cfg_out_en),
        .cfg_pwm_en   (cfg_pwm_en),
        .cfg_duty     (cfg_duty),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .cfg_pending  (cfg_pending),
        .cfg_commit   (cfg_commit),
        .state_o      (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n clocks sampling at each negedge and accumulate statistics.
    task automatic observe(input int n);
        for (int c = 0; c < 16; c++) hi_cnt[c] = 0;
        ps_cnt = 0; cm_cnt = 0; pd_cnt = 0; dr_cnt = 0; hi_total = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (k < 1536) win[k] = pwm_out;
            for (int c = 0; c < 16; c++) begin
                if (pwm_out[c]) begin
                    hi_cnt[c]++;
                    hi_total++;
                end
            end
            if (period_start) ps_cnt++;
            if (cfg_commit)   cm_cnt++;
            if (cfg_pending)  pd_cnt++;
            if (state_o == 2'd2) dr_cnt++;
        end
    endtask

    // Reset, load config while stopped, then start; returns just after RUN entry.
    task automatic start_run(input logic [15:0] oe, input logic [15:0] pe, input logic [7:0] d);
        run = 1'b0; cfg_update = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; cfg_update = 1'b1; cfg_out_en = oe; cfg_pwm_en = pe; cfg_duty = d;
        @(negedge clk);
        cfg_update = 1'b0;
        @(negedge clk);
        run = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b0; cfg_update = 1'b0;
        cfg_out_en = 16'h0000; cfg_pwm_en = 16'h0000; cfg_duty = 8'd0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({pwm_out, period_start, cfg_pending, cfg_commit, state_o} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got pwm=%h ps=%b pend=%b cm=%b st=%0d, expected all 0",
                     pwm_out, period_start, cfg_pending, cfg_commit, state_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic_duty();
        cfg_update = 1'b1; cfg_out_en = 16'h0001; cfg_pwm_en = 16'h0001; cfg_duty = 8'd64;
        @(negedge clk);
        n_checks++;
        if ({cfg_pending, cfg_commit} !== 2'b10) begin
            n_fail++;
            $display("FAIL stop_stage: got pend=%b cm=%b, expected pend=1 cm=0", cfg_pending, cfg_commit);
        end
        cfg_update = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({cfg_pending, cfg_commit, state_o} !== 4'b0100) begin
            n_fail++;
            $display("FAIL stop_commit: got pend=%b cm=%b st=%0d, expected pend=0 cm=1 st=0",
                     cfg_pending, cfg_commit, state_o);
        end
        run = 1'b1;
        @(negedge clk);
        n_checks++;
        if (state_o !== 2'd1 || pwm_out !== 16'h0000) begin
            n_fail++;
            $display("FAIL run_entry: got st=%0d pwm=%h, expected st=1 pwm=0000", state_o, pwm_out);
        end
        observe(512);
        n_checks++;
        if (hi_cnt[0] !== 128) begin
            n_fail++;
            $display("FAIL duty64_high: got %0d high clks, expected 128", hi_cnt[0]);
        end
        n_checks++;
        if (hi_total !== 128) begin
            n_fail++;
            $display("FAIL duty64_other_ch: got %0d total high, expected 128", hi_total);
        end
        n_checks++;
        if (win[0][0] !== 1'b1 || win[127][0] !== 1'b1 || win[128][0] !== 1'b0) begin
            n_fail++;
            $display("FAIL duty64_edges: got s0=%b s127=%b s128=%b, expected 1 1 0",
                     win[0][0], win[127][0], win[128][0]);
        end
        n_checks++;
        if (ps_cnt !== 1) begin
            n_fail++;
            $display("FAIL duty64_period_start: got %0d pulses, expected 1", ps_cnt);
        end
    endtask

    task automatic test_duty_limits();
        start_run(16'h0001, 16'h0001, 8'd0);
        observe(1536);
        n_checks++;
        if (hi_cnt[0] !== 0) begin
            n_fail++;
            $display("FAIL duty0: got %0d high clks, expected 0", hi_cnt[0]);
        end
        n_checks++;
        if (ps_cnt !== 3) begin
            n_fail++;
            $display("FAIL duty0_periods: got %0d pulses, expected 3", ps_cnt);
        end
        start_run(16'h0001, 16'h0001, 8'hFF);
        observe(1536);
        n_checks++;
        if (hi_cnt[0] !== 1536) begin
            n_fail++;
            $display("FAIL dutyFF: got %0d high clks, expected 1536", hi_cnt[0]);
        end
    endtask

    task automatic test_mixed_channels();
        start_run(16'hFFFF, 16'h00FF, 8'd128);
        observe(512);
        for (int c = 0; c < 16; c++) begin
            n_checks++;
            if (hi_cnt[c] !== ((c >= 8) ? 512 : 256)) begin
                n_fail++;
                $display("FAIL mixed_ch%0d: got %0d high clks, expected %0d", c, hi_cnt[c],
                         (c >= 8) ? 512 : 256);
            end
        end
        n_checks++;
        if (win[255] !== 16'hFFFF || win[256] !== 16'hFF00) begin
            n_fail++;
            $display("FAIL mixed_phase: got s255=%h s256=%h, expected FFFF FF00", win[255], win[256]);
        end
        n_checks++;
        if (ps_cnt !== 1) begin
            n_fail++;
            $display("FAIL mixed_period_start: got %0d pulses, expected 1", ps_cnt);
        end
    endtask

    task automatic test_midperiod_update();
        start_run(16'h0001, 16'h0001, 8'd64);
        observe(200);
        cfg_update = 1'b1; cfg_duty = 8'd200;
        @(negedge clk);
        n_checks++;
        if ({cfg_pending, cfg_commit} !== 2'b10) begin
            n_fail++;
            $display("FAIL mid_stage: got pend=%b cm=%b, expected pend=1 cm=0", cfg_pending, cfg_commit);
        end
        cfg_update = 1'b0;
        observe(310);
        n_checks++;
        if (hi_cnt[0] !== 0 || cm_cnt !== 0 || pd_cnt !== 310) begin
            n_fail++;
            $display("FAIL mid_hold_old: got high=%0d cm=%0d pend=%0d, expected 0 0 310",
                     hi_cnt[0], cm_cnt, pd_cnt);
        end
        @(negedge clk);
        n_checks++;
        if ({cfg_commit, cfg_pending, period_start} !== 3'b101) begin
            n_fail++;
            $display("FAIL mid_commit: got cm=%b pend=%b ps=%b, expected 1 0 1",
                     cfg_commit, cfg_pending, period_start);
        end
        observe(512);
        n_checks++;
        if (hi_cnt[0] !== 400) begin
            n_fail++;
            $display("FAIL mid_new_duty: got %0d high clks, expected 400", hi_cnt[0]);
        end
    endtask

    task automatic test_boundary_update();
        start_run(16'h0001, 16'h0001, 8'd64);
        observe(511);
        cfg_update = 1'b1; cfg_duty = 8'd200;
        @(negedge clk);
        n_checks++;
        if ({cfg_commit, cfg_pending, period_start} !== 3'b101) begin
            n_fail++;
            $display("FAIL bnd_commit: got cm=%b pend=%b ps=%b, expected 1 0 1",
                     cfg_commit, cfg_pending, period_start);
        end
        cfg_update = 1'b0;
        observe(512);
        n_checks++;
        if (hi_cnt[0] !== 400 || pd_cnt !== 0 || cm_cnt !== 0) begin
            n_fail++;
            $display("FAIL bnd_new_duty: got high=%0d pend=%0d cm=%0d, expected 400 0 0",
                     hi_cnt[0], pd_cnt, cm_cnt);
        end
    endtask

    task automatic test_drain_and_reset();
        start_run(16'h0001, 16'h0001, 8'd64);
        observe(20);
        run = 1'b0;
        @(negedge clk);
        n_checks++;
        if (state_o !== 2'd2) begin
            n_fail++;
            $display("FAIL drain_entry: got st=%0d, expected 2", state_o);
        end
        observe(490);
        n_checks++;
        if (dr_cnt !== 490 || hi_cnt[0] !== 107 || ps_cnt !== 0) begin
            n_fail++;
            $display("FAIL drain_run: got drain=%0d high=%0d ps=%0d, expected 490 107 0",
                     dr_cnt, hi_cnt[0], ps_cnt);
        end
        @(negedge clk);
        n_checks++;
        if (state_o !== 2'd0 || period_start !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_stop: got st=%0d ps=%b, expected 0 0", state_o, period_start);
        end
        observe(20);
        n_checks++;
        if (hi_total !== 0 || ps_cnt !== 0) begin
            n_fail++;
            $display("FAIL stop_quiet: got high=%0d ps=%0d, expected 0 0", hi_total, ps_cnt);
        end

        start_run(16'hFFFF, 16'h0000, 8'd0);
        observe(100);
        n_checks++;
        if (pwm_out !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL static_on: got pwm=%h, expected FFFF", pwm_out);
        end
        cfg_update = 1'b1; cfg_pwm_en = 16'hFFFF; cfg_duty = 8'd5;
        @(negedge clk);
        cfg_update = 1'b0; rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({pwm_out, period_start, cfg_pending, cfg_commit, state_o} !== 21'd0) begin
            n_fail++;
            $display("FAIL midrst: got pwm=%h ps=%b pend=%b cm=%b st=%0d, expected all 0",
                     pwm_out, period_start, cfg_pending, cfg_commit, state_o);
        end
        rst = 1'b0; run = 1'b0;
        observe(5);
        n_checks++;
        if (cm_cnt !== 0 || pd_cnt !== 0) begin
            n_fail++;
            $display("FAIL midrst_discard: got cm=%0d pend=%0d, expected 0 0", cm_cnt, pd_cnt);
        end
        run = 1'b1;
        observe(50);
        n_checks++;
        if (hi_total !== 0) begin
            n_fail++;
            $display("FAIL midrst_active_cleared: got %0d high samples, expected 0", hi_total);
        end
        run = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_duty();
        test_duty_limits();
        test_mixed_channels();
        test_midperiod_update();
        test_boundary_update();
        test_drain_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
